// File: rtl/pixel_capture.sv
// rtl/pixel_capture.sv - shadow framebuffer for the pixel-plot interface
// Captures plotted pixels and scans for a query colour, reporting count and bounding box.
module pixel_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic [2:0]  query_colour,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [14:0] match_count,
    output logic        found,
    output logic [7:0]  min_x,
    output logic [7:0]  max_x,
    output logic [6:0]  min_y,
    output logic [6:0]  max_y,
    output logic [14:0] oob_count
);
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(NPIX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [2:0]        mem [NPIX];
    logic              in_bounds, wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        rd_data_q;

    logic [1:0]        state_q, state_d;
    logic              flush_last_q, flush_last_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        scan_x_q, scan_x_d, tag_x_q, tag_x_d;
    logic [6:0]        scan_y_q, scan_y_d, tag_y_q, tag_y_d;
    logic              rd_valid_q, rd_valid_d;
    logic [2:0]        query_q, query_d;
    logic [14:0]       acc_count_q, acc_count_d;
    logic [7:0]        acc_min_x_q, acc_min_x_d, acc_max_x_q, acc_max_x_d;
    logic [6:0]        acc_min_y_q, acc_min_y_d, acc_max_y_q, acc_max_y_d;
    logic [14:0]       res_count_q, res_count_d;
    logic [7:0]        res_min_x_q, res_min_x_d, res_max_x_q, res_max_x_d;
    logic [6:0]        res_min_y_q, res_min_y_d, res_max_y_q, res_max_y_d;
    logic [14:0]       oob_q, oob_d;

    assign in_bounds = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    assign wr_en     = vga_plot && in_bounds;
    assign wr_addr   = ADDR_W'(32'(vga_y) * WIDTH + 32'(vga_x));
    assign rd_en     = (state_q == S_SCAN);

    // Read samples the array before this edge's write lands, so a collision returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= vga_colour;
        if (rd_en) rd_data_q <= mem[rd_addr_q];
    end

    always_comb begin
        state_d      = state_q;
        flush_last_d = flush_last_q;
        rd_addr_d    = rd_addr_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        rd_valid_d   = rd_en;
        tag_x_d      = scan_x_q;
        tag_y_d      = scan_y_q;
        query_d      = query_q;
        acc_count_d  = acc_count_q;
        acc_min_x_d  = acc_min_x_q;
        acc_max_x_d  = acc_max_x_q;
        acc_min_y_d  = acc_min_y_q;
        acc_max_y_d  = acc_max_y_q;
        res_count_d  = res_count_q;
        res_min_x_d  = res_min_x_q;
        res_max_x_d  = res_max_x_q;
        res_min_y_d  = res_min_y_q;
        res_max_y_d  = res_max_y_q;
        oob_d        = oob_q;

        if (vga_plot && !in_bounds && oob_q != 15'h7fff) oob_d = oob_q + 15'd1;

        if (rd_valid_q && rd_data_q == query_q) begin
            acc_count_d = acc_count_q + 15'd1;
            if (acc_count_q == '0) begin
                acc_min_x_d = tag_x_q;
                acc_max_x_d = tag_x_q;
                acc_min_y_d = tag_y_q;
                acc_max_y_d = tag_y_q;
            end else begin
                if (tag_x_q < acc_min_x_q) acc_min_x_d = tag_x_q;
                if (tag_x_q > acc_max_x_q) acc_max_x_d = tag_x_q;
                if (tag_y_q < acc_min_y_q) acc_min_y_d = tag_y_q;
                if (tag_y_q > acc_max_y_q) acc_max_y_d = tag_y_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_SCAN;
                    query_d      = query_colour;
                    acc_count_d  = '0;
                    acc_min_x_d  = '0;
                    acc_max_x_d  = '0;
                    acc_min_y_d  = '0;
                    acc_max_y_d  = '0;
                    rd_addr_d    = '0;
                    scan_x_d     = '0;
                    scan_y_d     = '0;
                    flush_last_d = 1'b0;
                end
            end
            S_SCAN: begin
                rd_addr_d = rd_addr_q + 1'b1;
                if (scan_x_q == 8'(WIDTH - 1)) begin
                    scan_x_d = '0;
                    scan_y_d = scan_y_q + 7'd1;
                end else begin
                    scan_x_d = scan_x_q + 8'd1;
                end
                if (rd_addr_q == ADDR_W'(NPIX - 1)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // First cycle folds in the last datum, second publishes the accumulators.
                if (!flush_last_q) begin
                    flush_last_d = 1'b1;
                end else begin
                    state_d     = S_DONE;
                    res_count_d = acc_count_q;
                    res_min_x_d = acc_min_x_q;
                    res_max_x_d = acc_max_x_q;
                    res_min_y_d = acc_min_y_q;
                    res_max_y_d = acc_max_y_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_last_q <= 1'b0;
            rd_addr_q    <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            rd_valid_q   <= 1'b0;
            tag_x_q      <= '0;
            tag_y_q      <= '0;
            query_q      <= '0;
            acc_count_q  <= '0;
            acc_min_x_q  <= '0;
            acc_max_x_q  <= '0;
            acc_min_y_q  <= '0;
            acc_max_y_q  <= '0;
            res_count_q  <= '0;
            res_min_x_q  <= '0;
            res_max_x_q  <= '0;
            res_min_y_q  <= '0;
            res_max_y_q  <= '0;
            oob_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_last_q <= flush_last_d;
            rd_addr_q    <= rd_addr_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            rd_valid_q   <= rd_valid_d;
            tag_x_q      <= tag_x_d;
            tag_y_q      <= tag_y_d;
            query_q      <= query_d;
            acc_count_q  <= acc_count_d;
            acc_min_x_q  <= acc_min_x_d;
            acc_max_x_q  <= acc_max_x_d;
            acc_min_y_q  <= acc_min_y_d;
            acc_max_y_q  <= acc_max_y_d;
            res_count_q  <= res_count_d;
            res_min_x_q  <= res_min_x_d;
            res_max_x_q  <= res_max_x_d;
            res_min_y_q  <= res_min_y_d;
            res_max_y_q  <= res_max_y_d;
            oob_q        <= oob_d;
        end
    end

    assign busy        = (state_q == S_SCAN) || (state_q == S_FLUSH);
    assign done        = (state_q == S_DONE);
    assign match_count = res_count_q;
    assign found       = (res_count_q != '0);
    assign min_x       = res_min_x_q;
    assign max_x       = res_max_x_q;
    assign min_y       = res_min_y_q;
    assign max_y       = res_max_y_q;
    assign oob_count   = oob_q;
endmodule

// File: tb/tb_pixel_capture.sv
// tb/tb_pixel_capture.sv - self-checking bench for pixel_capture
// Random plots plus a circle are mirrored into a behavioural framebuffer model.
module tb_pixel_capture;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
    localparam int LAT = N + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [2:0]  query_colour;
    logic        start;
    logic        busy, done, found;
    logic [14:0] match_count, oob_count;
    logic [7:0]  min_x, max_x;
    logic [6:0]  min_y, max_y;

    always #5 clk = ~clk;

    pixel_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .query_colour(query_colour), .start(start),
        .busy(busy), .done(done), .match_count(match_count), .found(found),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .oob_count(oob_count)
    );

    int n_checks = 0;
    int n_pass = 0;
    int mem_m [N];
    int oob_m = 0;
    int exp_cnt, exp_minx, exp_maxx, exp_miny, exp_maxy;
    int ctab [5] = '{0, 1, 3, 4, 6};
    int edges, busy_low;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic plot(input int x, input int y, input int c);
        @(negedge clk);
        vga_x = 8'(x);
        vga_y = 7'(y);
        vga_colour = 3'(c);
        vga_plot = 1'b1;
        if (x < W && y < H) mem_m[y * W + x] = c;
        else if (oob_m < 32767) oob_m++;
    endtask

    task automatic plot_off();
        @(negedge clk);
        vga_plot = 1'b0;
    endtask

    task automatic circle(input int cx, input int cy, input int r, input int c);
        int px = r;
        int py = 0;
        int d = 1 - r;
        while (py <= px) begin
            plot(cx + px, cy + py, c); plot(cx - px, cy + py, c);
            plot(cx + px, cy - py, c); plot(cx - px, cy - py, c);
            plot(cx + py, cy + px, c); plot(cx - py, cy + px, c);
            plot(cx + py, cy - px, c); plot(cx - py, cy - px, c);
            py++;
            if (d <= 0) d += 2 * py + 1;
            else begin
                px--;
                d += 2 * (py - px) + 1;
            end
        end
    endtask

    function automatic void model_query(input int q);
        exp_cnt = 0; exp_minx = W; exp_maxx = -1; exp_miny = H; exp_maxy = -1;
        for (int i = 0; i < N; i++) begin
            if (mem_m[i] == q) begin
                exp_cnt++;
                if (i % W < exp_minx) exp_minx = i % W;
                if (i % W > exp_maxx) exp_maxx = i % W;
                if (i / W < exp_miny) exp_miny = i / W;
                if (i / W > exp_maxy) exp_maxy = i / W;
            end
        end
        if (exp_cnt == 0) begin
            exp_minx = 0; exp_maxx = 0; exp_miny = 0; exp_maxy = 0;
        end
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_count"}, int'(match_count), exp_cnt);
        check({tag, "_found"}, int'(found), int'(exp_cnt != 0));
        check({tag, "_min_x"}, int'(min_x), exp_minx);
        check({tag, "_max_x"}, int'(max_x), exp_maxx);
        check({tag, "_min_y"}, int'(min_y), exp_miny);
        check({tag, "_max_y"}, int'(max_y), exp_maxy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_count"}, int'(match_count), 0);
        check({tag, "_found"}, int'(found), 0);
        check({tag, "_bounds"}, int'(min_x) + int'(max_x) + int'(min_y) + int'(max_y), 0);
        check({tag, "_oob"}, int'(oob_count), 0);
    endtask

    // Edge 0 is the first posedge after the call; edges = first edge after which done is seen.
    task automatic wait_done(output int e_done, output int n_busy_low);
        e_done = -1;
        n_busy_low = 0;
        for (int e = 0; e < LAT + 100; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                e_done = e;
                break;
            end
            if (!busy) n_busy_low++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        query_colour = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                plot(x, y, 0);
        plot(160, 0, 6);
        plot(0, 120, 6);
        plot(255, 127, 6);
        plot(159, 119, 5);
        plot_off();
        check("oob_edges", int'(oob_count), 3);

        repeat (300) plot($urandom_range(0, 175), $urandom_range(0, 127), ctab[$urandom_range(0, 4)]);
        circle(80, 60, 40, 2);
        plot(5, 7, 2);
        plot(150, 3, 2);
        plot(80, 110, 2);
        plot_off();
        check("oob_random", int'(oob_count), oob_m);

        // Scan aborted by reset at scan cycle 5000, with an ignored start pulse mid-scan.
        @(negedge clk);
        query_colour = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        query_colour = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy", int'(busy), 1);
        check("mid_done", int'(done), 0);
        repeat (4900) @(negedge clk);
        check("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        oob_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Held start: first scan for green, then re-run in DONE with a new query.
        model_query(2);
        @(negedge clk);
        query_colour = 3'd2;
        start = 1'b1;
        wait_done(edges, busy_low);
        check("green_latency", edges, LAT);
        check("green_busy_low", busy_low, 0);
        check("green_busy_done", int'(busy), 0);
        check_results("green");
        check("green_min_x_abs", int'(min_x), 5);
        check("green_max_x_abs", int'(max_x), 150);
        check("green_min_y_abs", int'(min_y), 3);
        check("green_max_y_abs", int'(max_y), 110);
        query_colour = 3'd7;

        model_query(7);
        wait_done(edges, busy_low);
        check("rerun_latency", edges, LAT);
        check("rerun_busy_low", busy_low, 0);
        check_results("none");
        start = 1'b0;
        check("final_oob", int'(oob_count), oob_m);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_capture.md
Name: pixel_capture

Overview:
- Responder end of the pixel-plot interface (x, y, colour, plot) that fillscreen and circle drive into the VGA adapter.
- Captures every plotted pixel into an internal shadow framebuffer.
- On a start/done handshake, scans the framebuffer in raster order and reports:
  - the number of pixels matching a query colour;
  - the bounding box of those pixels.
- Used in simulation and on-board self-check to verify drawing engines without reading the VGA output.

Parameters:
- WIDTH, 160, framebuffer columns; valid x is 0..WIDTH-1.
- HEIGHT, 120, framebuffer rows; valid y is 0..HEIGHT-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vga_x  input  8  plot x coordinate.
- vga_y  input  7  plot y coordinate.
- vga_colour  input  3  plot colour.
- vga_plot  input  1  write strobe; one pixel per cycle while high.
- query_colour  input  3  colour to match; sampled with start.
- start  input  1  begin scan; sampled only in IDLE or DONE.
- busy  output  1  high while scanning.
- done  output  1  high in DONE until the next accepted start.
- match_count  output  15  number of matching pixels (max 19200).
- found  output  1  match_count != 0.
- min_x, max_x  output  8 each  bounding box columns of matches.
- min_y, max_y  output  7 each  bounding box rows of matches.
- oob_count  output  15  plot strobes dropped as out-of-bounds; saturates at 32767.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - busy=0, done=0, match_count=0, found=0, min_x=0, max_x=0, min_y=0, max_y=0, oob_count=0.
  - RAM contents are NOT cleared. The bench must plot a full screen (e.g. with fillscreen) before relying on the contents.
- Storage:
  - WIDTH*HEIGHT x 3-bit RAM, address = y*WIDTH + x.
  - One synchronous write port and one synchronous read port; read latency 1 cycle.
- Write path:
  - Independent of FSM state, including during a scan.
  - Active when vga_plot=1.
  - If x<WIDTH and y<HEIGHT: write vga_colour at the next clock edge.
  - Otherwise: drop the write and increment oob_count (saturating).
  - Same-cycle read and write to the same address: the read returns the old data.
- FSM states: IDLE, SCAN, FLUSH, DONE.
  - IDLE: start=1 -> latch query_colour, clear accumulators, addr=0, go to SCAN.
  - SCAN:
    - busy=1; issue one read per cycle at addr; advance x, then y, raster order.
    - After issuing addr WIDTH*HEIGHT-1, go to FLUSH.
    - Compare/accumulate uses data returned one cycle after the read, tagged with the delayed (x, y).
  - FLUSH: busy=1; accumulate the last datum; go to DONE.
  - DONE:
    - busy=0, done=1; outputs hold.
    - start=1 -> re-run exactly as from IDLE; done drops on that edge.
- Latency: with start sampled at edge 0, done rises at edge N+2 (N = WIDTH*HEIGHT; 19202 for the defaults).
- Accumulation per matched pixel:
  - count+1.
  - min_x = min(min_x, x), max_x = max(max_x, x); same rule for y.
  - First match initialises all four bounds.
- Result outputs:
  - match_count, found and the bounding box are registered and update only on entry to DONE.
  - During SCAN they hold their previous values.
  - With no matches: found=0 and all bounds are 0.
- start while busy: ignored.
- Reset mid-scan: abort immediately to IDLE with all outputs zeroed; the RAM write in that cycle is not guaranteed.

Test Plan:
- Full-screen plot of colour 0, then start with query 0 -> done at edge 19202, match_count=19200, found=1, bounds (0,159,0,119).
- Fill 0, plot green (3'b010) at (5,7), (150,3), (80,110); query 2 -> match_count=3, bounds (5,150,3,110); query 3'b111 -> found=0, count 0, bounds 0.
- Fill 0, then circle centre (80,60), radius 40, colour 3'b010; query 2 -> bounds (40,120,20,100), found=1, match_count equals the number of unique pixels the bench model plots.
- Plot at (160,0), (0,120), (255,127), (159,119) -> oob_count=3; only (159,119) stored; a query for its colour counts it.
- Assert rst_n low at scan cycle 5000 -> busy=0, done=0, all results 0 during reset; a new start after release completes normally in 19202 cycles.
- Pulse start during SCAN and hold start high in DONE -> mid-scan start ignored; in DONE a second full scan runs, done low for 19202 cycles, then high again with identical results.
